// File: rtl/relm_ps2_pkg.sv
// relm_ps2_pkg: shared state encodings, frame length and pop_q flag
// positions for the PS/2 device endpoint, plus the 11-bit frame builder.
package relm_ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_TX,
    S_RX,
    S_ACK,
    S_GAP
  } state_t;

  localparam int FRAME_BITS = 11;
  localparam int POP_OVR    = 9;
  localparam int POP_ERR    = 8;

  // start 0, data LSB first, odd parity, stop 1 (bit 0 goes out first)
  function automatic logic [FRAME_BITS-1:0] ps2_frame(
    input logic [7:0] d
  );
    return {1'b1, ~^d, d, 1'b0};
  endfunction

endpackage

// File: rtl/relm_ps2_filter.sv
// relm_ps2_filter: FILT-deep glitch filter; q only moves when all samples agree.
// Ports: clk, rst (async high), d (raw line), q (filtered line, resets high).
module relm_ps2_filter #(
  parameter int FILT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [FILT-1:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh <= '1;
      q  <= 1'b1;
    end else begin
      sh <= {sh[FILT-2:0], d};
      if (&sh)
        q <= 1'b1;
      else if (~|sh)
        q <= 1'b0;
    end
  end

endmodule

// File: rtl/relm_ps2_device.sv
// relm_ps2_device: PS/2 device-side endpoint. Generates the PS/2 clock,
// sends device-to-host frames and receives host-to-device commands.
// Ports: clk, rst (async high); push_d/push_retry (tx byte bus);
// pop_d/pop_q (rx byte bus: [WD]=empty, [9]=overrun, [8]=error, [7:0]=byte);
// ps2_clk_in/ps2_dat_in (line sense); ps2_clk_oe/ps2_dat_oe (pull low).
// Build option RELM_PS2DEV_TXFIFO_EN: 16-entry tx FIFO instead of one register.
module relm_ps2_device
  import relm_ps2_pkg::*;
#(
  parameter int WD   = 32,
  parameter int DIV  = 2000,
  parameter int GAP  = 5000,
  parameter int FILT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [WD:0] push_d,
  output logic        push_retry,
  input  logic [WD:0] pop_d,
  output logic [WD:0] pop_q,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic        ps2_clk_oe,
  output logic        ps2_dat_oe
);

  localparam int CMAX = (GAP > DIV) ? GAP : DIV;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int HALF = DIV / 2;

  logic fclk, fdat;

  relm_ps2_filter #(.FILT(FILT)) u_fclk (
    .clk(clk), .rst(rst), .d(ps2_clk_in), .q(fclk)
  );
  relm_ps2_filter #(.FILT(FILT)) u_fdat (
    .clk(clk), .rst(rst), .d(ps2_dat_in), .q(fdat)
  );

  logic       tx_full, tx_rdy, deq, accept;
  logic [7:0] tx_byte;

  assign accept     = push_d[WD] && (!tx_full || deq);
  assign push_retry = tx_full && !deq;

`ifdef RELM_PS2DEV_TXFIFO_EN
  logic [7:0] mem [16];
  logic [3:0] wp, rp;
  logic [4:0] fcnt;

  assign tx_full = fcnt[4];
  assign tx_rdy  = fcnt != 5'd0;
  assign tx_byte = mem[rp];

  always_ff @(posedge clk)
    if (accept)
      mem[wp] <= push_d[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else begin
      if (accept)
        wp <= wp + 4'd1;
      if (deq)
        rp <= rp + 4'd1;
      fcnt <= fcnt + 5'(accept) - 5'(deq);
    end
  end
`else
  logic       full_q;
  logic [7:0] byte_q;

  assign tx_full = full_q;
  assign tx_rdy  = full_q;
  assign tx_byte = byte_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      byte_q <= '0;
    end else if (accept) begin
      full_q <= 1'b1;
      byte_q <= push_d[7:0];
    end else if (deq) begin
      full_q <= 1'b0;
    end
  end
`endif

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      bitn, bit_n;
  logic            ph, ph_n;
  logic            tick, last, mid, samp, rx_done;
  logic [FRAME_BITS-1:0] frame;

  assign frame = ps2_frame(tx_byte);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      bitn  <= '0;
      ph    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bitn  <= bit_n;
      ph    <= ph_n;
    end
  end

  // ph=0: released high phase, ph=1: clock pulled low
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_n      = bitn;
    ph_n       = ph;
    deq        = 1'b0;
    rx_done    = 1'b0;
    samp       = 1'b0;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    tick = cnt == CW'(DIV - 1);
    last = tick && ph && (bitn == 4'(FRAME_BITS - 1));
    mid  = !ph && (cnt == CW'(HALF));
    if (state inside {S_TX, S_RX, S_ACK}) begin
      if (tick) begin
        cnt_n = '0;
        ph_n  = ~ph;
        if (ph)
          bit_n = bitn + 4'd1;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        ph_n  = 1'b0;
        if (!fclk)
          state_n = S_INHIBIT;
        else if (!fdat)
          state_n = S_RX;
        else if (tx_rdy)
          state_n = S_TX;
      end
      S_INHIBIT: begin
        cnt_n = '0;
        if (fclk)
          state_n = S_GAP;
      end
      S_TX: begin
        ps2_clk_oe = ph;
        ps2_dat_oe = ~frame[bitn];
        if (mid && !fclk) begin
          state_n = S_INHIBIT;
          cnt_n   = '0;
          bit_n   = '0;
          ph_n    = 1'b0;
        end else if (last) begin
          deq     = 1'b1;
          state_n = S_GAP;
        end
      end
      S_RX: begin
        ps2_clk_oe = ph;
        samp = mid && (bitn != 4'd0);
        if (last) begin
          rx_done = 1'b1;
          state_n = S_ACK;
          bit_n   = '0;
        end
      end
      S_ACK: begin
        ps2_clk_oe = ph;
        ps2_dat_oe = 1'b1;
        if (tick && ph)
          state_n = S_GAP;
      end
      S_GAP: begin
        if (cnt == CW'(GAP - 1)) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // rx_sh after 10 samples: [7:0] data, [8] parity, [9] stop
  logic [9:0] rx_sh;
  logic       rx_v, rx_ovr, rx_err;
  logic [7:0] rx_byte;
  logic       pop;

  assign pop = pop_d[WD];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sh   <= '0;
      rx_v    <= 1'b0;
      rx_ovr  <= 1'b0;
      rx_err  <= 1'b0;
      rx_byte <= '0;
    end else begin
      if (samp)
        rx_sh <= {fdat, rx_sh[9:1]};
      if (rx_done && (!rx_v || pop)) begin
        rx_v    <= 1'b1;
        rx_ovr  <= 1'b0;
        rx_err  <= ~rx_sh[9] | ~(^rx_sh[8:0]);
        rx_byte <= rx_sh[7:0];
      end else if (rx_done) begin
        rx_ovr <= 1'b1;
      end else if (pop && rx_v) begin
        rx_v    <= 1'b0;
        rx_ovr  <= 1'b0;
        rx_err  <= 1'b0;
        rx_byte <= '0;
      end
    end
  end

  always_comb begin
    pop_q          = '0;
    pop_q[WD]      = ~rx_v;
    pop_q[POP_OVR] = rx_ovr;
    pop_q[POP_ERR] = rx_err;
    pop_q[7:0]     = rx_byte;
  end

  logic unused;
  assign unused = ^{push_d[WD-1:8], pop_d[WD-1:0]};

endmodule

// File: tb/tb_relm_ps2_device.sv
// tb_relm_ps2_device: directed bench for relm_ps2_device with a host model
// on open-drain PS/2 lines; default build (no tx FIFO).
module tb_relm_ps2_device;

  localparam int WD   = 32;
  localparam int DIV  = 20;
  localparam int GAP  = 50;
  localparam int FILT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [WD:0]   push_d = '0;
  logic          push_retry;
  logic [WD:0]   pop_d = '0;
  logic [WD:0]   pop_q;
  logic          ps2_clk_oe, ps2_dat_oe;
  logic          host_clk_low = 1'b0;
  logic          host_dat_low = 1'b0;
  logic          clk_line, dat_line;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  assign clk_line = ~(ps2_clk_oe | host_clk_low);
  assign dat_line = ~(ps2_dat_oe | host_dat_low);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  relm_ps2_device #(
    .WD(WD), .DIV(DIV), .GAP(GAP), .FILT(FILT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .push_d(push_d),
    .push_retry(push_retry),
    .pop_d(pop_d),
    .pop_q(pop_q),
    .ps2_clk_in(clk_line),
    .ps2_dat_in(dat_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  task automatic wait_edge(input bit rise, output bit ok);
    bit p, c;
    ok = 1'b0;
    p = clk_line;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      c = clk_line;
      if (rise ? (!p && c) : (p && !c)) begin
        ok = 1'b1;
        break;
      end
      p = c;
    end
    if (!ok) begin
      errors++;
      $display("FAIL edge_timeout rise=%0d", rise);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    push_d = '0;
    push_d[WD] = 1'b1;
    push_d[7:0] = b;
    @(negedge clk);
    push_d = '0;
  endtask

  task automatic pop();
    @(negedge clk);
    pop_d = '0;
    pop_d[WD] = 1'b1;
    @(negedge clk);
    pop_d = '0;
  endtask

  task automatic capture(output logic [10:0] f, output int t0,
                         output int t1);
    bit ok;
    f = '0;
    t0 = 0;
    t1 = 0;
    for (int k = 0; k < 11; k++) begin
      wait_edge(1'b0, ok);
      if (!ok) return;
      f[k] = dat_line;
      if (k == 0) t0 = cyc;
      t1 = cyc;
    end
  endtask

  task automatic wait_retry_low();
    for (int i = 0; i < 3000; i++) begin
      if (push_retry == 1'b0) return;
      @(negedge clk);
    end
    errors++;
    $display("FAIL retry_timeout push_retry stuck at 1");
  endtask

  task automatic idle_wait();
    repeat (2 * DIV + GAP + 20) @(negedge clk);
  endtask

  task automatic count_falls(input int n, output int falls);
    bit p;
    falls = 0;
    p = clk_line;
    repeat (n) begin
      @(negedge clk);
      if (p && !clk_line) falls++;
      p = clk_line;
    end
  endtask

  // host side of a host-to-device frame; returns 3 cycles into the ACK
  task automatic host_send(input logic [7:0] d, input logic par);
    bit ok;
    @(negedge clk);
    host_dat_low = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      wait_edge(1'b0, ok);
      if (!ok) begin
        host_dat_low = 1'b0;
        return;
      end
      if (n <= 8)
        host_dat_low = ~d[n-1];
      else if (n == 9)
        host_dat_low = ~par;
      else
        host_dat_low = 1'b0;
    end
    wait_edge(1'b1, ok);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [WD:0] exp;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    exp = '0;
    exp[WD] = 1'b1;
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_lines got %b%b want 00", ps2_clk_oe, ps2_dat_oe);
    end
    checks++;
    if (push_retry !== 1'b0) begin
      errors++;
      $display("FAIL reset_retry got %b want 0", push_retry);
    end
    checks++;
    if (pop_q !== exp) begin
      errors++;
      $display("FAIL reset_pop_q got %h want %h", pop_q, exp);
    end
    rst = 1'b0;
    repeat (FILT + 4) @(negedge clk);
  endtask

  task automatic test_tx();
    logic [10:0] f;
    int t0, t1, bad;
    checks++;
    if (push_retry !== 1'b0) begin
      errors++;
      $display("FAIL tx_retry_idle got %b want 0", push_retry);
    end
    push(8'h1C);
    checks++;
    if (push_retry !== 1'b1) begin
      errors++;
      $display("FAIL tx_retry_busy got %b want 1", push_retry);
    end
    capture(f, t0, t1);
    checks++;
    if (f !== 11'h438) begin
      errors++;
      $display("FAIL tx_frame_1c got %h want 438", f);
    end
    checks++;
    if (t1 - t0 !== 20 * DIV) begin
      errors++;
      $display("FAIL tx_period got %0d want %0d", t1 - t0, 20 * DIV);
    end
    wait_retry_low();
    bad = 0;
    repeat (GAP - 2) begin
      @(negedge clk);
      if (ps2_clk_oe || ps2_dat_oe) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL tx_gap_idle got %0d driven cycles want 0", bad);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_rx_ok();
    logic [WD:0] exp;
    host_send(8'hED, 1'b1);
    checks++;
    if (ps2_dat_oe !== 1'b1) begin
      errors++;
      $display("FAIL rx_ack got %b want 1", ps2_dat_oe);
    end
    exp = '0;
    exp[7:0] = 8'hED;
    checks++;
    if (pop_q !== exp) begin
      errors++;
      $display("FAIL rx_pop_q got %h want %h", pop_q, exp);
    end
    pop();
    exp = '0;
    exp[WD] = 1'b1;
    checks++;
    if (pop_q !== exp) begin
      errors++;
      $display("FAIL rx_pop_clear got %h want %h", pop_q, exp);
    end
    pop();
    checks++;
    if (pop_q !== exp) begin
      errors++;
      $display("FAIL rx_pop_empty got %h want %h", pop_q, exp);
    end
    idle_wait();
  endtask

  task automatic test_rx_parity_err();
    logic [WD:0] exp;
    host_send(8'hED, 1'b0);
    exp = '0;
    exp[8] = 1'b1;
    exp[7:0] = 8'hED;
    checks++;
    if (pop_q !== exp) begin
      errors++;
      $display("FAIL rx_parity_err got %h want %h", pop_q, exp);
    end
    pop();
    exp = '0;
    exp[WD] = 1'b1;
    checks++;
    if (pop_q !== exp) begin
      errors++;
      $display("FAIL rx_err_clear got %h want %h", pop_q, exp);
    end
    idle_wait();
  endtask

  task automatic test_inhibit();
    logic [10:0] f;
    int t0, t1;
    bit ok;
    push(8'hAA);
    for (int k = 0; k < 6; k++) wait_edge(1'b0, ok);
    host_clk_low = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
      errors++;
      $display("FAIL inhibit_release got %b%b want 00",
               ps2_clk_oe, ps2_dat_oe);
    end
    checks++;
    if (push_retry !== 1'b1) begin
      errors++;
      $display("FAIL inhibit_keep got %b want 1", push_retry);
    end
    host_clk_low = 1'b0;
    capture(f, t0, t1);
    checks++;
    if (f !== 11'h754) begin
      errors++;
      $display("FAIL inhibit_resend got %h want 754", f);
    end
    wait_retry_low();
    idle_wait();
  endtask

  task automatic test_collision();
    logic [WD:0] exp;
    logic [10:0] f;
    int t0, t1;
    @(negedge clk);
    host_dat_low = 1'b1;
    repeat (FILT) @(negedge clk);
    push_d = '0;
    push_d[WD] = 1'b1;
    push_d[7:0] = 8'h55;
    @(negedge clk);
    push_d = '0;
    host_send(8'h3C, 1'b1);
    checks++;
    if (ps2_dat_oe !== 1'b1) begin
      errors++;
      $display("FAIL coll_ack got %b want 1", ps2_dat_oe);
    end
    exp = '0;
    exp[7:0] = 8'h3C;
    checks++;
    if (pop_q !== exp) begin
      errors++;
      $display("FAIL coll_rx got %h want %h", pop_q, exp);
    end
    repeat (2 * DIV) @(negedge clk);
    capture(f, t0, t1);
    checks++;
    if (f !== 11'h6AA) begin
      errors++;
      $display("FAIL coll_tx got %h want 6aa", f);
    end
    pop();
    wait_retry_low();
    idle_wait();
  endtask

  task automatic test_overrun();
    logic [WD:0] exp;
    logic [10:0] f;
    int t0, t1, falls;
    host_send(8'h11, 1'b1);
    idle_wait();
    host_send(8'h22, 1'b1);
    exp = '0;
    exp[9] = 1'b1;
    exp[7:0] = 8'h11;
    checks++;
    if (pop_q !== exp) begin
      errors++;
      $display("FAIL ovr_keep got %h want %h", pop_q, exp);
    end
    pop();
    exp = '0;
    exp[WD] = 1'b1;
    checks++;
    if (pop_q !== exp) begin
      errors++;
      $display("FAIL ovr_clear got %h want %h", pop_q, exp);
    end
    idle_wait();
    push(8'h01);
    @(negedge clk);
    push_d = '0;
    push_d[WD] = 1'b1;
    push_d[7:0] = 8'h02;
    checks++;
    if (push_retry !== 1'b1) begin
      errors++;
      $display("FAIL busy_retry got %b want 1", push_retry);
    end
    @(negedge clk);
    push_d = '0;
    capture(f, t0, t1);
    checks++;
    if (f !== 11'h402) begin
      errors++;
      $display("FAIL busy_frame got %h want 402", f);
    end
    wait_retry_low();
    count_falls(2 * GAP + 200, falls);
    checks++;
    if (falls !== 0) begin
      errors++;
      $display("FAIL busy_dropped got %0d falls want 0", falls);
    end
  endtask

  task automatic test_reset_midframe();
    logic [WD:0] exp;
    int falls;
    bit ok;
    push(8'h33);
    wait_edge(1'b0, ok);
    wait_edge(1'b0, ok);
    repeat (DIV + 3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 ||
        push_retry !== 1'b0) begin
      errors++;
      $display("FAIL midrst_lines got %b%b%b want 000",
               ps2_clk_oe, ps2_dat_oe, push_retry);
    end
    @(negedge clk);
    rst = 1'b0;
    count_falls(300, falls);
    checks++;
    if (falls !== 0) begin
      errors++;
      $display("FAIL midrst_discard got %0d falls want 0", falls);
    end
    exp = '0;
    exp[WD] = 1'b1;
    checks++;
    if (pop_q !== exp) begin
      errors++;
      $display("FAIL midrst_pop_q got %h want %h", pop_q, exp);
    end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx_ok();
    test_rx_parity_err();
    test_inhibit();
    test_collision();
    test_overrun();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
